// File: rtl/i2s_tx.sv
// i2s_tx: I2S bus-master transmitter; divides clk into BCLK/LRCLK and shifts stereo frames out MSB-first.
// `define I2S_TX_LJ_EN selects left-justified framing (no one-bit delay, LRCLK high = left).
module i2s_tx #(
  parameter int DATA_W   = 16,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0][DATA_W-1:0] audio_in,
  input  logic                   sample_en,
  output logic                   i2s_bclk,
  output logic                   i2s_lrclk,
  output logic                   i2s_sdata,
  output logic                   sample_req,
  output logic                   underrun
);
  localparam int FRAME_W = 2 * SLOT_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] RIGHT_BIT = CNT_W'(SLOT_W);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
`ifdef I2S_TX_LJ_EN
  localparam logic LJ = 1'b1;
`else
  localparam logic LJ = 1'b0;
`endif

  logic [DIV_W-1:0]          div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic                      bclk_q, bclk_d;
  logic                      lrclk_q, lrclk_d;
  logic                      sdata_q, sdata_d;
  logic                      sample_req_q, sample_req_d;
  logic                      underrun_q, underrun_d;
  logic                      fresh_q, fresh_d;
  logic [1:0][DATA_W-1:0]    hold_q, hold_d;
  logic [FRAME_W-1:0]        shift_q, shift_d;
  logic [FRAME_W-1:0]        load_word;
  logic                      div_wrap;
  logic                      fall;
  logic                      frame_load;

  always_comb begin
    div_wrap   = (div_cnt_q == DIV_LAST);
    div_cnt_d  = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d     = bclk_q ^ div_wrap;
    fall       = div_wrap & bclk_q;
    frame_load = fall & (bit_cnt_q == LAST_BIT);

    load_word = '0;
    load_word[FRAME_W-1 -: DATA_W] = hold_q[0];
    load_word[SLOT_W-1 -: DATA_W]  = hold_q[1];

    hold_d       = sample_en ? audio_in : hold_q;
    // A sample arriving in the load cycle is kept for the next frame.
    fresh_d      = frame_load ? sample_en : (fresh_q | sample_en);
    sample_req_d = frame_load;
    underrun_d   = frame_load & ~fresh_q;

    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    shift_d   = shift_q;
    if (fall) begin
      bit_cnt_d = frame_load ? '0 : bit_cnt_q + CNT_W'(1);
      lrclk_d   = (bit_cnt_d >= RIGHT_BIT) ^ LJ;
      if (frame_load && LJ) begin
        sdata_d = load_word[FRAME_W-1];
        shift_d = load_word << 1;
      end else if (frame_load) begin
        // MSB still holds the previous frame's last bit: the I2S one-bit delay.
        sdata_d = shift_q[FRAME_W-1];
        shift_d = load_word;
      end else begin
        sdata_d = shift_q[FRAME_W-1];
        shift_d = shift_q << 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt_q    <= '0;
      bit_cnt_q    <= LAST_BIT;
      bclk_q       <= 1'b0;
      lrclk_q      <= 1'b0;
      sdata_q      <= 1'b0;
      sample_req_q <= 1'b0;
      underrun_q   <= 1'b0;
      fresh_q      <= 1'b0;
      hold_q       <= '0;
      shift_q      <= '0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      bclk_q       <= bclk_d;
      lrclk_q      <= lrclk_d;
      sdata_q      <= sdata_d;
      sample_req_q <= sample_req_d;
      underrun_q   <= underrun_d;
      fresh_q      <= fresh_d;
      hold_q       <= hold_d;
      shift_q      <= shift_d;
    end
  end

  assign i2s_bclk   = bclk_q;
  assign i2s_lrclk  = lrclk_q;
  assign i2s_sdata  = sdata_q;
  assign sample_req = sample_req_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: two instances (SLOT_W=32/BCLK_DIV=2 and SLOT_W=16/BCLK_DIV=1) against a frame-level reference model.
module tb_i2s_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef I2S_TX_LJ_EN
  localparam bit LJ = 1'b1;
`else
  localparam bit LJ = 1'b0;
`endif

  logic             reset_n = 1'b0;
  logic [1:0][15:0] audio0 = '0, audio1 = '0;
  logic             en0 = 1'b0, en1 = 1'b0;
  logic bclk0, lr0, sd0, req0, und0;
  logic bclk1, lr1, sd1, req1, und1;

  i2s_tx #(.DATA_W(16), .SLOT_W(32), .BCLK_DIV(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .audio_in(audio0), .sample_en(en0),
    .i2s_bclk(bclk0), .i2s_lrclk(lr0), .i2s_sdata(sd0),
    .sample_req(req0), .underrun(und0)
  );

  i2s_tx #(.DATA_W(16), .SLOT_W(16), .BCLK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .audio_in(audio1), .sample_en(en1),
    .i2s_bclk(bclk1), .i2s_lrclk(lr1), .i2s_sdata(sd1),
    .sample_req(req1), .underrun(und1)
  );

  int checks = 0;
  int failures = 0;
  int n = 0;          // clk edges since reset release
  bit rst_g = 1'b0;

  // Frame-level model state per instance
  int          dv[2] = '{2, 1};
  int          sl[2] = '{32, 16};
  logic [15:0] hl[2], hr[2], cl[2], cr[2], pl[2], pr[2];
  bit          fr[2], req_e[2], und_e[2];
  int          k_m[2], m_m[2], f_m[2];
  logic [63:0] cap;
  logic        bclk0_prev;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (n=%0d)", tag, act, exp, n);
    end
  endtask

  // Bit at MSB-first frame position pos of the word {L, pad, R, pad}
  function automatic logic wbit(input logic [15:0] l, input logic [15:0] r, input int s, input int pos);
    logic [15:0] t;
    if (pos < s) begin
      if (pos >= 16) return 1'b0;
      t = l >> (15 - pos);
    end else begin
      if (pos - s >= 16) return 1'b0;
      t = r >> (15 - (pos - s));
    end
    return t[0];
  endfunction

  task automatic model_edge(input logic rst, input bit ev[2], input logic [15:0] lv[2], input logic [15:0] rv[2]);
    rst_g = rst;
    if (!rst) begin
      n = 0;
      cap = '0;
      for (int i = 0; i < 2; i++) begin
        hl[i] = '0; hr[i] = '0; cl[i] = '0; cr[i] = '0; pl[i] = '0; pr[i] = '0;
        fr[i] = 1'b0; req_e[i] = 1'b0; und_e[i] = 1'b0;
      end
    end else begin
      n++;
      for (int i = 0; i < 2; i++) begin
        int p, s;
        bit ld;
        p = 2 * dv[i];
        s = sl[i];
        ld = (n % p == 0) && (((n / p) - 1) % (2 * s) == 0);
        req_e[i] = ld;
        und_e[i] = ld && !fr[i];
        if (ld) begin
          pl[i] = cl[i]; pr[i] = cr[i];
          cl[i] = hl[i]; cr[i] = hr[i];
          fr[i] = ev[i];
        end else begin
          fr[i] = fr[i] | ev[i];
        end
        if (ev[i]) begin
          hl[i] = lv[i]; hr[i] = rv[i];
        end
      end
    end
  endtask

  task automatic compare();
    int off;
    off = LJ ? 0 : 1;
    for (int i = 0; i < 2; i++) begin
      int p, s, m, k;
      logic eb, el, es;
      logic ab, al, asd, ar, au;
      p = 2 * dv[i];
      s = sl[i];
      m = n / p;
      k = (m > 0) ? (m - 1) % (2 * s) : 0;
      eb = 1'((n / dv[i]) % 2);
      if (m == 0) begin
        el = 1'b0; es = 1'b0;
      end else begin
        el = (k >= s) ^ LJ;
        if (LJ)          es = wbit(cl[i], cr[i], s, k);
        else if (k == 0) es = wbit(pl[i], pr[i], s, 2 * s - 1);
        else             es = wbit(cl[i], cr[i], s, k - 1);
      end
      k_m[i] = k;
      m_m[i] = m;
      f_m[i] = (m > 0) ? (m - 1) / (2 * s) : 0;
      ab  = (i == 0) ? bclk0 : bclk1;
      al  = (i == 0) ? lr0   : lr1;
      asd = (i == 0) ? sd0   : sd1;
      ar  = (i == 0) ? req0  : req1;
      au  = (i == 0) ? und0  : und1;
      chk($sformatf("bclk%0d", i),     32'(ab),  32'(eb));
      chk($sformatf("lrclk%0d", i),    32'(al),  32'(el));
      chk($sformatf("sdata%0d", i),    32'(asd), 32'(es));
      chk($sformatf("req%0d", i),      32'(ar),  32'(req_e[i]));
      chk($sformatf("underrun%0d", i), 32'(au),  32'(und_e[i]));
    end

    if (rst_g && bclk0 && !bclk0_prev && m_m[0] > 0 && f_m[0] == 0)
      cap[6'(63 - k_m[0])] = sd0;
    bclk0_prev = bclk0;

    if (rst_g) begin
      case (n)
        1:    chk("bclk_before_rise", 32'(bclk0), 32'd0);
        2:    chk("bclk_first_rise", 32'(bclk0), 32'd1);
        4: begin
          chk("bclk_first_fall", 32'(bclk0), 32'd0);
          chk("first_load_req", 32'(req0), 32'd1);
        end
        66: begin
          chk("slot16_pos0_sdata", 32'(sd1), 32'd1);
          chk("slot16_pos0_lrclk", 32'(lr1), 32'(LJ));
        end
        131:  chk("lrclk_left_slot", 32'(lr0), 32'(LJ));
        132:  chk("lrclk_right_slot", 32'(lr0), 32'(!LJ));
        259: begin
          chk("left_word", 32'(cap[(63 - off) -: 16]), 32'h0000A5C3);
          chk("left_pad", 32'(cap[(47 - off) -: 15]), 32'd0);
          chk("right_word", 32'(cap[(31 - off) -: 16]), 32'h00000F01);
        end
        260: begin
          chk("underrun_pulse", 32'(und0), 32'd1);
          chk("underrun_req", 32'(req0), 32'd1);
        end
        516:  chk("underrun_cleared", 32'(und0), 32'd0);
        772:  chk("collision_load_und", 32'(und0), 32'd0);
        1028: chk("collision_next_und", 32'(und0), 32'd0);
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input logic rst, input bit e0, input logic [15:0] l0, input logic [15:0] r0,
                     input bit e1, input logic [15:0] l1, input logic [15:0] r1);
    bit          ev[2];
    logic [15:0] lv[2], rv[2];
    @(negedge clk);
    reset_n = rst;
    en0 = e0; audio0[0] = l0; audio0[1] = r0;
    en1 = e1; audio1[0] = l1; audio1[1] = r1;
    ev[0] = e0; lv[0] = l0; rv[0] = r0;
    ev[1] = e1; lv[1] = l1; rv[1] = r1;
    @(posedge clk);
    model_edge(rst, ev, lv, rv);
    #1;
    compare();
  endtask

  task automatic run_random(input int cycles);
    for (int t = 0; t < cycles; t++)
      cyc(1'b1, $urandom_range(0, 299) == 0, 16'($urandom), 16'($urandom),
                $urandom_range(0, 49) == 0,  16'($urandom), 16'($urandom));
  endtask

  // Directed opening sequence; expects n == 0 on entry
  task automatic run_init();
    for (int t = 0; t < 1100; t++) begin
      int          nn;
      bit          e0, e1;
      logic [15:0] l0, r0, l1, r1;
      nn = n + 1;
      e0 = (nn == 1) || (nn == 300) || (nn == 600) || (nn == 772);
      l0 = (nn == 1) ? 16'hA5C3 : (nn == 772) ? 16'h1234 : 16'($urandom);
      r0 = (nn == 1) ? 16'h0F01 : 16'($urandom);
      e1 = (nn == 1) || (nn > 100 && $urandom_range(0, 39) == 0);
      l1 = (nn == 1) ? (16'h8000 | 16'($urandom)) : 16'($urandom);
      r1 = (nn == 1) ? 16'h0001 : 16'($urandom);
      cyc(1'b1, e0, l0, r0, e1, l1, r1);
    end
  endtask

  initial begin
    int t;
    bclk0_prev = 1'b0;
    cap = '0;
    repeat (5) cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
    chk("reset_outputs0", 32'({bclk0, lr0, sd0, req0, und0}), 32'd0);
    run_init();
    run_random(1500);

    t = 0;
    while (!(m_m[0] > 0 && k_m[0] == 40) && t < 400) begin
      run_random(1);
      t++;
    end
    chk("reach_bit40", 32'(k_m[0]), 32'd40);
    cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
    chk("midreset_outputs0", 32'({bclk0, lr0, sd0, req0, und0}), 32'd0);
    chk("midreset_outputs1", 32'({bclk1, lr1, sd1, req1, und1}), 32'd0);
    run_init();
    run_random(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Stereo I2S transmitter at the output end of the FX chain.
- Accepts parallel stereo samples on the same audio/sample_en interface the FX blocks produce.
- Generates BCLK/LRCLK as bus master and serializes samples MSB-first to the DAC/codec.
- Pulses sample_req once per frame so the upstream chain can pace itself.

Parameters:
- DATA_W, 16: bits per audio sample; two's complement, MSB-first on the wire.
- SLOT_W, 32: BCLK periods per channel slot; must satisfy SLOT_W >= DATA_W.
- BCLK_DIV, 4: clk cycles per BCLK half-period; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset; synchronous, active-low.
- audio_in  input  [1:0][DATA_W-1:0]  stereo sample; [0] = left, [1] = right.
- sample_en  input  1  one-cycle strobe; audio_in valid.
- i2s_bclk  output  1  bit clock.
- i2s_lrclk  output  1  word select; 0 = left, 1 = right.
- i2s_sdata  output  1  serial data.
- sample_req  output  1  one-cycle pulse at each frame load.
- underrun  output  1  one-cycle pulse; frame loaded without a fresh sample.

Behaviour:
- Reset state (reset_n low at a clk edge): all outputs 0; div_cnt = 0; bit_cnt = 2*SLOT_W-1; holding, shift register and fresh flag all 0.
- BCLK generation:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - On wrap, i2s_bclk toggles; BCLK period = 2*BCLK_DIV clk cycles.
  - First rising edge occurs BCLK_DIV cycles after reset release.
- Falling-edge event: the clk cycle in which i2s_bclk toggles 1->0. All serial state changes only on falling-edge events, registered with the bclk toggle, so sdata and lrclk are stable across every rising edge.
- bit_cnt: advances 0..2*SLOT_W-1 on each falling-edge event and wraps.
- i2s_lrclk: 0 for bit_cnt < SLOT_W, otherwise 1.
- Holding register and fresh flag:
  - sample_en captures audio_in into the holding register in any cycle and sets fresh.
- Frame load (falling-edge event where bit_cnt wraps to 0):
  - The pre-update holding value loads into a 2*SLOT_W shift register laid out as {L, (SLOT_W-DATA_W) zeros, R, zeros}.
  - sample_req pulses high for exactly that clk cycle.
  - fresh clears.
  - If fresh was 0 at load, underrun pulses in the same cycle and the previous holding value is retransmitted.
- sample_en coinciding with the frame-load cycle: the new sample goes to holding only and is sent next frame; fresh ends the cycle set; no underrun next frame.
- Multiple sample_en within one frame: last one wins; no error.
- Serial data (standard I2S, one-bit delay after the LRCLK transition):
  - At frame position k >= 1, i2s_sdata = shift register bit k-1 (MSB-first order).
  - At k = 0, i2s_sdata = last bit of the previous frame: 0 when SLOT_W > DATA_W, right LSB when SLOT_W == DATA_W.
- First frame after reset:
  - The first falling-edge event (2*BCLK_DIV cycles after release) is a frame load.
  - underrun fires unless sample_en arrived before it.
- Reset asserted mid-frame: everything returns to reset state on that edge; the partial frame is abandoned; no sample_req/underrun pulse in that cycle.
- No arithmetic on sample data: bits are passed verbatim, and padding bits are always 0.

Optional Feature:
- Macro: I2S_TX_LJ_EN.
- Defined: left-justified format.
  - i2s_sdata at frame position k = shift register bit k, with no one-bit delay; MSB coincides with the LRCLK transition.
  - i2s_lrclk polarity inverted: 1 = left, 0 = right.
- Not defined: standard I2S exactly as in Behaviour.
- All other timing, sample_req and underrun rules are identical in both builds.

Test Plan:
- Reset/clocking (BCLK_DIV=2, SLOT_W=32): hold reset 5 cycles, release.
  - All outputs 0 during reset.
  - bclk rises at cycle 2, falls at cycle 4, period 4.
  - lrclk toggles every 128 clk.
  - sample_req every 256 clk.
- Serialization: sample_en with L=0xA5C3, R=0x0F01 before the first load.
  - Left slot bits 1..16 = 1010010111000011; bits 17..31 = 0.
  - Right slot bits 1..16 = 0000111100000001.
  - Sampled on bclk rising edges.
- Underrun: no sample_en for one frame.
  - underrun pulses with sample_req.
  - Same L/R retransmitted.
  - Next sample_en clears the condition; no pulse on the following frame.
- Collision: sample_en with L=0x1234 in the exact frame-load cycle.
  - Current frame carries the old sample.
  - Next frame carries 0x1234; no underrun.
- Mid-frame reset: assert reset_n low at bit_cnt=40 for 1 cycle.
  - Outputs 0 next cycle.
  - Restart matches the post-reset sequence of the first test.
- SLOT_W=DATA_W=16 with R=0x0001: frame position 0 of the next frame outputs 1 (right LSB).
  - With I2S_TX_LJ_EN: MSB appears at position 0 and lrclk is high for the left slot.
